// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

   // Widest operand the helper functions handle; the divider's WIDTH must not exceed it.
   localparam int unsigned MAX_W = 64;

   // Quotient reported on divide-by-zero (truncated to the operand width by the user).
   localparam logic [MAX_W-1:0] DIV0_QUOT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      ITER = 2'd2,
      FIX  = 2'd3
   } div_state_e;

   // Two's-complement negation when neg is set; the result is correct modulo any narrower width.
   function automatic logic [MAX_W-1:0] neg_cond(input logic [MAX_W-1:0] v, input logic neg);
      return neg ? (~v + MAX_W'(1)) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: produces one quotient bit.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] quo_nxt,
   output logic             trial_neg
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // Shift {rem,quo} left, trial-subtract the divisor, keep the result only if non-negative.
   always_comb begin
      shifted   = {rem, quo[WIDTH-1]};
      trial     = shifted - {1'b0, divisor};
      trial_neg = trial[WIDTH];
      rem_nxt   = trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nxt   = {quo[WIDTH-2:0], ~trial_neg};
   end

endmodule

// File: rtl/div_seq_unit.sv
// Multicycle signed/unsigned restoring divider: LOOut = quotient, HIOut = remainder.
module div_seq_unit
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             DivCtrl,
   input  logic             Signed,
   input  logic [WIDTH-1:0] FromA,
   input  logic [WIDTH-1:0] FromB,
   output logic             Busy,
   output logic             DivDone,
   output logic             Div0,
   output logic [WIDTH-1:0] HIOut,
   output logic [WIDTH-1:0] LOOut
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned MSB   = WIDTH - 1;

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] magb_q, magb_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sgn_q, sgn_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             dz_q, dz_d;
   logic             busy_d, done_d, div0_d;
   logic [WIDTH-1:0] hi_d, lo_d;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] step_rem, step_quo;
   logic             unused_trial_neg;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem       (rem_q),
      .quo       (quo_q),
      .divisor   (magb_q),
      .rem_nxt   (step_rem),
      .quo_nxt   (step_quo),
      .trial_neg (unused_trial_neg)
   );

   // Operand magnitudes; only meaningful while in PREP.
   always_comb begin
      mag_a = WIDTH'(neg_cond(MAX_W'(a_q), sgn_q & a_q[MSB]));
      mag_b = WIDTH'(neg_cond(MAX_W'(b_q), sgn_q & b_q[MSB]));
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      magb_d  = magb_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      busy_d  = Busy;
      done_d  = 1'b0;
      div0_d  = Div0;
      hi_d    = HIOut;
      lo_d    = LOOut;

      case (state_q)
         IDLE: begin
            if (DivCtrl) begin
               a_d     = FromA;
               b_d     = FromB;
               sgn_d   = Signed;
               div0_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = PREP;
            end
         end
         PREP: begin
            magb_d = mag_b;
            negq_d = sgn_q & (a_q[MSB] ^ b_q[MSB]);
            negr_d = sgn_q & a_q[MSB];
            if (b_q == '0) begin
               dz_d    = 1'b1;
               state_d = FIX;
            end else begin
               dz_d    = 1'b0;
               rem_d   = '0;
               quo_d   = mag_a;
               cnt_d   = CNT_W'(WIDTH);
               state_d = ITER;
            end
         end
         ITER: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (dz_q) begin
               div0_d = 1'b1;
               lo_d   = WIDTH'(DIV0_QUOT);
               hi_d   = a_q;
            end else begin
               lo_d = WIDTH'(neg_cond(MAX_W'(quo_q), negq_q));
               hi_d = WIDTH'(neg_cond(MAX_W'(rem_q), negr_q));
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         magb_q  <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
         Busy    <= 1'b0;
         DivDone <= 1'b0;
         Div0    <= 1'b0;
         HIOut   <= '0;
         LOOut   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         magb_q  <= magb_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
         Busy    <= busy_d;
         DivDone <= done_d;
         Div0    <= div0_d;
         HIOut   <= hi_d;
         LOOut   <= lo_d;
      end
   end

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed bench for div_seq_unit (WIDTH = 32).
module tb_div_seq_unit;

   localparam int unsigned WIDTH = 32;

   logic             Clock;
   logic             Reset;
   logic             DivCtrl;
   logic             Signed;
   logic [WIDTH-1:0] FromA;
   logic [WIDTH-1:0] FromB;
   logic             Busy;
   logic             DivDone;
   logic             Div0;
   logic [WIDTH-1:0] HIOut;
   logic [WIDTH-1:0] LOOut;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   div_seq_unit #(.WIDTH(WIDTH)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .DivCtrl (DivCtrl),
      .Signed  (Signed),
      .FromA   (FromA),
      .FromB   (FromB),
      .Busy    (Busy),
      .DivDone (DivDone),
      .Div0    (Div0),
      .HIOut   (HIOut),
      .LOOut   (LOOut)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Starts an operation at the current sample point and follows it to DivDone.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                         input logic exp_div0, input int exp_lat, input int glitch);
      int n;
      int busy_n;
      FromA   = a;
      FromB   = b;
      Signed  = s;
      DivCtrl = 1'b1;
      @(posedge Clock); #1;
      DivCtrl = 1'b0;
      FromA   = ~a;
      FromB   = ~b;
      Signed  = ~s;
      check({tag, " div0@accept"}, 32'(Div0), 32'd0);
      busy_n = (Busy === 1'b1) ? 1 : 0;
      n = 0;
      while (DivDone !== 1'b1 && n < 100) begin
         if (glitch > 0 && n == glitch) begin
            DivCtrl = 1'b1;
            FromA   = 32'd999;
            FromB   = 32'd1;
            Signed  = 1'b0;
         end else if (glitch > 0 && n == glitch + 1) begin
            DivCtrl = 1'b0;
         end
         @(posedge Clock); #1;
         n++;
         if (Busy === 1'b1) busy_n++;
      end
      check({tag, " latency"}, 32'(n), 32'(exp_lat));
      check({tag, " busy"}, 32'(busy_n), 32'(exp_lat));
      check({tag, " quot"}, LOOut, exp_q);
      check({tag, " rem"}, HIOut, exp_r);
      check({tag, " div0"}, 32'(Div0), 32'(exp_div0));
   endtask

   initial begin
      int done_seen;
      Reset   = 1'b0;
      DivCtrl = 1'b0;
      Signed  = 1'b0;
      FromA   = '0;
      FromB   = '0;
      #1;
      check("rst busy", 32'(Busy), 32'd0);
      check("rst done", 32'(DivDone), 32'd0);
      check("rst div0", 32'(Div0), 32'd0);
      check("rst hi", HIOut, 32'd0);
      check("rst lo", LOOut, 32'd0);
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b1;
      @(posedge Clock); #1;

      // Sign combinations, each started in the previous DivDone cycle.
      run_op("s 7/3",   32'd7,         32'd3,         1'b1, 32'd2,          32'd1,          1'b0, 34, 0);
      run_op("s 7/-3",  32'd7,         32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFE,  32'd1,          1'b0, 34, 0);
      run_op("s -7/3",  32'hFFFF_FFF9, 32'd3,         1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 34, 0);
      run_op("s -7/-3", 32'hFFFF_FFF9, 32'hFFFF_FFFD, 1'b1, 32'd2,          32'hFFFF_FFFF,  1'b0, 34, 0);
      run_op("u ff/2",  32'hFFFF_FFFF, 32'd2,         1'b0, 32'h7FFF_FFFF,  32'd1,          1'b0, 34, 0);
      run_op("s ff/2",  32'hFFFF_FFFF, 32'd2,         1'b1, 32'd0,          32'hFFFF_FFFF,  1'b0, 34, 0);
      run_op("div0",    32'h1234_5678, 32'd0,         1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 2,  0);
      run_op("ovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000,  32'd0,          1'b0, 34, 0);
      run_op("glitch",  32'd1000,      32'd10,        1'b0, 32'd100,        32'd0,          1'b0, 34, 5);

      // Results hold and DivDone stays a single pulse while idle.
      repeat (3) @(posedge Clock);
      #1;
      check("hold done", 32'(DivDone), 32'd0);
      check("hold lo", LOOut, 32'd100);
      check("hold busy", 32'(Busy), 32'd0);

      // Asynchronous reset in the middle of the iteration phase.
      FromA   = 32'd12345;
      FromB   = 32'd11;
      Signed  = 1'b0;
      DivCtrl = 1'b1;
      @(posedge Clock); #1;
      DivCtrl = 1'b0;
      repeat (10) @(posedge Clock);
      #3;
      check("pre-rst busy", 32'(Busy), 32'd1);
      Reset = 1'b0;
      #1;
      check("arst busy", 32'(Busy), 32'd0);
      check("arst done", 32'(DivDone), 32'd0);
      check("arst div0", 32'(Div0), 32'd0);
      check("arst hi", HIOut, 32'd0);
      check("arst lo", LOOut, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clock); #1;
         if (i == 3) Reset = 1'b1;
         if (DivDone === 1'b1) done_seen++;
      end
      check("arst no done", 32'(done_seen), 32'd0);
      check("arst idle busy", 32'(Busy), 32'd0);

      run_op("u 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
